// File: rtl/core_pkg.sv
// core_pkg: shared core constants and the writeback request type (rd + data)
package core_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: power-of-two FIFO of T; ports clk/rst_n, clr (sync empty), push/pop (ignored when full/empty), din, full/empty, head (current front entry)
module wb_fifo import core_pkg::*; #(
  parameter int DEPTH = 2,
  parameter type T = wb_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  T mem [DEPTH];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: busy scoreboard + LSU-priority / buffered-ALU writeback; ports clk/rst_n/flush, issue_* in with issue_stall out, alu_* in with alu_ready out, lsu_* in, registered wr_en/wr_addr/wr_data out
module writeback_arbiter import core_pkg::*; #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int ALU_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  issue_stall,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data
);
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic full, empty, push, pop, sel_valid, issue_fire;
  wb_req_t alu_req, head, sel;
  assign issue_stall = !flush && issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]);
  assign issue_fire = !flush && issue_valid && !issue_stall && issue_rd != '0;
  assign alu_ready = !full;
  assign push = alu_valid && !flush;
  // the head only leaves the FIFO in a cycle the LSU does not claim the port
  assign pop = !flush && !lsu_valid && !empty;
  assign sel_valid = lsu_valid || !empty;
  assign alu_req = wb_req_t'{rd: alu_rd, data: alu_data};
  assign sel = lsu_valid ? wb_req_t'{rd: lsu_rd, data: lsu_data} : head;
  wb_fifo #(.DEPTH(ALU_DEPTH), .T(wb_req_t)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(push),
    .pop(pop),
    .din(alu_req),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // clear first so a same-index issue set wins
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (issue_fire) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      busy <= flush ? '0 : busy_nxt;
      wr_en <= !flush && sel_valid && sel.rd != '0;
      if (!flush && sel_valid) begin
        wr_addr <= sel.rd;
        wr_data <= sel.data;
      end
    end
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width.
REQ-002 SHALL have parameter ALU_DEPTH, default 2, meaning ALU result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have ports issue_valid/issue_rd/issue_rs1/issue_rs2  input  1/5/5/5  instruction entering execute.
REQ-007 SHALL have port issue_stall  output  1  hazard, issue not accepted this cycle.
REQ-008 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/XLEN  ALU result offer.
REQ-009 SHALL have port alu_ready  output  1  ALU result accepted when alu_valid&&alu_ready.
REQ-010 SHALL have ports lsu_valid/lsu_rd/lsu_data  input  1/5/XLEN  load result, always accepted (no ready).
REQ-011 SHALL have ports wr_en/wr_addr/wr_data  output  1/5/XLEN  register-file write port, all registered.

Function
REQ-012 SHALL keep a 32-bit busy scoreboard; busy[0] permanently 0.
REQ-013 SHALL drive issue_stall = issue_valid && (busy[rs1]||busy[rs2]||busy[rd]), combinational.
REQ-014 SHALL set busy[issue_rd] on the edge where issue_valid && !issue_stall && issue_rd!=0.
REQ-015 SHALL clear busy[wr_addr] on the edge ending a cycle with wr_en=1; set wins if same index both set and cleared.
REQ-016 SHALL push ALU results into an ALU_DEPTH FIFO; alu_ready = !full, independent of pop that cycle.
REQ-017 SHALL give LSU fixed priority: lsu_valid -> next-cycle write of lsu_rd/lsu_data; else FIFO non-empty -> pop head, write next cycle; else wr_en=0 next cycle.
REQ-018 SHALL yield latency 1 cycle for LSU, minimum 2 cycles for ALU (push edge, then pop edge).
REQ-019 SHALL consume results with rd=0 normally but keep wr_en=0 for them.
REQ-020 SHALL support simultaneous push and pop in one cycle when not full; count unchanged.
REQ-021 SHALL wrap FIFO pointers modulo ALU_DEPTH; count width holds 0..ALU_DEPTH.
REQ-022 SHALL on flush: empty FIFO, clear busy, wr_en=0 next cycle, ignore issue/alu/lsu inputs that cycle; issue_stall=0 during flush.
REQ-023 SHALL never write two results in one cycle; at most one wr_en pulse per cycle.

Reset
REQ-024 SHALL on rst_n low asynchronously: busy=0, FIFO empty, wr_en=0, wr_addr=0, wr_data=0.
REQ-025 SHALL after reset drive alu_ready=1, issue_stall=0 until inputs change.
REQ-026 SHALL discard any in-flight result if reset asserts mid-operation; no write after release.

Structure
REQ-027 SHALL take XLEN default, REG_ADDR_W=5, NUM_REGS=32 and struct wb_req_t {rd, data} from shared package core_pkg.
REQ-028 SHALL instantiate one sub-module wb_fifo (parameterised depth/type, push/pop/full/empty/head).

Verification
REQ-029 SHALL cover: issue rd=5 accepted; next cycle issue rs1=5 -> issue_stall=1 until cycle after wr_en with wr_addr=5.
REQ-030 SHALL cover: alu rd=3 data=0xAA at edge N, lsu idle -> wr_en=1 wr_addr=3 wr_data=0xAA during cycle N+2.
REQ-031 SHALL cover: lsu rd=4 and alu rd=6 same cycle -> rd 4 written at N+1, rd 6 at N+2.
REQ-032 SHALL cover: lsu_valid held 4 cycles, alu pushes 3 results -> alu_ready=0 after 2, FIFO drains in order after LSU stops.
REQ-033 SHALL cover: alu rd=0 data=0xFF -> accepted, wr_en stays 0; busy[0] never set.
REQ-034 SHALL cover: flush with FIFO holding 2 entries and busy[7]=1 -> no writes after, busy=0, alu_ready=1 next cycle.
